// File: rtl/pipelined_rca_if.sv
// pipelined_rca_if: operand/result bundle for pipelined_rca.
//   master (source): drives en, in_valid, A, B, cin; observes the results.
//   slave  (adder) : drives out_valid, S, cout, ovf, op_count.
interface pipelined_rca_if #(parameter int WIDTH = 8);
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic [15:0]      op_count;
  modport master (output en, in_valid, A, B, cin, input out_valid, S, cout, ovf, op_count);
  modport slave  (input en, in_valid, A, B, cin, output out_valid, S, cout, ovf, op_count);
endinterface

// File: rtl/pipelined_rca.sv
// pipelined_rca: WIDTH-stage bit-serial pipelined ripple-carry adder.
//   clk, rst : rising-edge clock, async active-high reset
//   bus      : slave side of pipelined_rca_if (en, in_valid, A, B, cin in;
//              out_valid, S, cout, ovf, op_count out)
module pipelined_rca #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  pipelined_rca_if.slave bus
);
  typedef logic [WIDTH-1:0] word_t;
  logic [WIDTH-1:0]  val_q, val_d, cry_q, cry_d, cry_src;
  word_t [WIDTH-1:0] sum_q, sum_d, sum_src, a_src, b_src;
  word_t [WIDTH-2:0] a_q, a_d, b_q, b_d;
  logic              cmsb_q, cmsb_d;
  logic [15:0]       cnt_q, cnt_d;
  // Stage k reads stage k-1's registers; slot 0 of each source vector is the
  // port side (operands, cin, an empty deskew word).
  always_comb begin
    val_d   = {val_q[WIDTH-2:0], bus.in_valid};
    cry_src = {cry_q[WIDTH-2:0], bus.cin};
    sum_src = {sum_q[WIDTH-2:0], word_t'(0)};
    a_src   = {a_q, bus.A};
    b_src   = {b_q, bus.B};
    a_d     = a_src[WIDTH-2:0];
    b_d     = b_src[WIDTH-2:0];
    sum_d   = sum_src;
    cry_d   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      sum_d[k][k] = a_src[k][k] ^ b_src[k][k] ^ cry_src[k];
      cry_d[k]    = (a_src[k][k] & b_src[k][k]) | (cry_src[k] & (a_src[k][k] ^ b_src[k][k]));
    end
    cmsb_d = cry_src[WIDTH-1];
    cnt_d  = cnt_q + 16'(val_d[WIDTH-1]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= '0;
      cry_q  <= '0;
      sum_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cmsb_q <= 1'b0;
      cnt_q  <= '0;
    end else if (bus.en) begin
      val_q  <= val_d;
      cry_q  <= cry_d;
      sum_q  <= sum_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cmsb_q <= cmsb_d;
      cnt_q  <= cnt_d;
    end
  end
  assign bus.out_valid = val_q[WIDTH-1];
  assign bus.S         = sum_q[WIDTH-1];
  assign bus.cout      = cry_q[WIDTH-1];
  assign bus.ovf       = cmsb_q ^ cry_q[WIDTH-1];
  assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: directed self-checking bench for pipelined_rca (WIDTH=8).
module tb_pipelined_rca;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pipelined_rca_if #(.WIDTH(W)) bus ();
  pipelined_rca #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  // Expected {ovf, cout, S} from plain integer arithmetic.
  function automatic logic [9:0] calc(input logic [7:0] a, input logic [7:0] b, input logic c);
    int u, sa, sb, s;
    logic [8:0] u9;
    u  = int'(a) + int'(b) + int'(c);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa + sb + int'(c);
    u9 = u[8:0];
    return {(s > 127 || s < -128), u9};
  endfunction
  // Reference: results delayed W enabled edges, counted as they land.
  logic       mv [W];
  logic [9:0] md [W];
  logic [15:0] mcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < W; k++) begin
        mv[k] <= 1'b0;
        md[k] <= '0;
      end
      mcnt <= '0;
    end else if (bus.en) begin
      mv[0] <= bus.in_valid;
      md[0] <= calc(bus.A, bus.B, bus.cin);
      for (int k = 1; k < W; k++) begin
        mv[k] <= mv[k-1];
        md[k] <= md[k-1];
      end
      if (mv[W-2]) mcnt <= mcnt + 16'd1;
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      #1;
      chk("model_out_valid", 32'(bus.out_valid), 32'(mv[W-1]));
      chk("model_op_count", 32'(bus.op_count), 32'(mcnt));
      if (mv[W-1] || rst) chk("model_result", 32'({bus.ovf, bus.cout, bus.S}), mv[W-1] ? 32'(md[W-1]) : 32'd0);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic rnd_ops(input logic v);
    bus.A = 8'($urandom);
    bus.B = 8'($urandom);
    bus.cin = 1'($urandom);
    bus.in_valid = v;
  endtask
  task automatic op_once(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [9:0] exp, input int exp_cnt);
    int n;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.cin = c;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, W - 1);
    chk("literal_result", 32'({bus.ovf, bus.cout, bus.S}), 32'(exp));
    @(posedge clk);
    #1;
    chk("single_pulse", 32'(bus.out_valid), 0);
    chk("literal_op_count", 32'(bus.op_count), exp_cnt);
  endtask
  task automatic stim();
    int v, first, last, n;
    logic [28:0] snap;
    bus.en = 1'b1;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.cin = 1'b0;
    // reset held with random inputs
    repeat (5) begin
      @(negedge clk);
      rnd_ops(1'($urandom));
      bus.en = 1'($urandom);
      #1;
      chk("rst_idle", 32'({bus.out_valid, bus.S, bus.cout, bus.ovf, bus.op_count}), 0);
    end
    do_reset();
    bus.en = 1'b1;
    op_once(8'h0F, 8'h01, 1'b0, {1'b0, 1'b0, 8'h10}, 1);
    op_once(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}, 2);
    op_once(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80}, 3);
    op_once(8'h80, 8'h80, 1'b1, {1'b1, 1'b1, 8'h01}, 4);
    // streaming
    do_reset();
    v = 0; first = -1; last = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rnd_ops(i < 20);
      if (bus.out_valid) begin
        v++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("stream_count", v, 20);
    chk("stream_first", first, W);
    chk("stream_gapless", last - first + 1, 20);
    chk("stream_op_count", 32'(bus.op_count), 20);
    // stall with 5 ops in flight
    do_reset();
    v = 0; first = -1; last = -1; snap = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 7) snap = {bus.out_valid, bus.S, bus.cout, bus.ovf, bus.op_count, 2'b00};
      if (i >= 8 && i <= 10) chk("stall_frozen", 32'({bus.out_valid, bus.S, bus.cout, bus.ovf, bus.op_count, 2'b00}), 32'(snap));
      rnd_ops(i < 5);
      bus.en = !(i >= 7 && i < 10);
      if (bus.out_valid) begin
        v++;
        if (first < 0) first = i;
        last = i;
      end
    end
    bus.en = 1'b1;
    chk("stall_count", v, 5);
    chk("stall_first", first, W + 3);
    chk("stall_gapless", last - first + 1, 5);
    chk("stall_op_count", 32'(bus.op_count), 5);
    // async reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rnd_ops(1'b1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midrst_seen", 32'(bus.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_zero", 32'({bus.S, bus.cout, bus.ovf, bus.op_count}), 0);
    @(negedge clk);
    rst = 1'b0;
    v = 0;
    repeat (20) begin
      @(negedge clk);
      rnd_ops(1'b0);
      if (bus.out_valid) v++;
    end
    chk("midrst_no_stale", v, 0);
    chk("midrst_op_count", 32'(bus.op_count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask
  initial begin
    fork
      cmp_loop();
      stim();
    join_any
  end
endmodule
